// File: rtl/sysbus_if.sv
// Sysbus request/response channel between the cache arbiter (master) and a memory target (slave).
interface sysbus_if;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory target: acknowledges one-cycle line requests, streams 8 read beats
// after a fixed latency or absorbs 8 write beats into a line-organised array.
module sysbus_mem_responder #(
  parameter int unsigned MEM_LINES  = 1024,
  parameter int unsigned RD_LATENCY = 4
) (
  input  logic     clk,
  input  logic     reset,
  sysbus_if.slave  bus,
  output logic     busy,
  output logic     bad_type
);

  localparam int unsigned LINE_W  = $clog2(MEM_LINES);
  localparam int unsigned WORDS   = 8;
  localparam int unsigned ADDR_W  = LINE_W + 3;
  localparam logic [3:0]  TYPE_MEMORY = 4'b0001;
  localparam logic        WR_READ     = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WAIT,
    S_RESP,
    S_WDATA
  } state_t;

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [12:0]       tag_q, tag_d;
  logic [2:0]        beat_q, beat_d;
  logic [3:0]        lat_q, lat_d;

  logic              reqack_d, respcyc_d, busy_d, bad_type_d;
  logic [63:0]       resp_d;
  logic [12:0]       resptag_d;

  logic              we_c;
  logic [2:0]        rbeat_c;
  logic [63:0]       rdata_c;

  logic [63:0]       mem [MEM_LINES*WORDS];

  assign rdata_c = mem[ADDR_W'({line_q, rbeat_c})];

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    tag_d      = tag_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    reqack_d   = 1'b0;
    respcyc_d  = bus.respcyc;
    resp_d     = bus.resp;
    resptag_d  = bus.resptag;
    bad_type_d = bad_type;
    we_c       = 1'b0;
    rbeat_c    = 3'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.reqcyc) begin
          line_d   = bus.req[6 +: LINE_W];
          tag_d    = bus.reqtag;
          reqack_d = 1'b1;
          state_d  = S_ACK;
        end
      end

      S_ACK: begin
        beat_d = 3'd0;
        if (tag_q[11:8] != TYPE_MEMORY) begin
          bad_type_d = 1'b1;
          state_d    = S_IDLE;
        end else if (tag_q[12] == WR_READ) begin
          if (RD_LATENCY == 1) begin
            state_d   = S_RESP;
            respcyc_d = 1'b1;
            resp_d    = rdata_c;
            resptag_d = tag_q;
          end else begin
            lat_d   = 4'(RD_LATENCY - 1);
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WDATA;
        end
      end

      // The last WAIT cycle loads beat 0 so it is visible exactly RD_LATENCY cycles after ack
      S_WAIT: begin
        if (lat_q <= 4'd1) begin
          lat_d     = 4'd0;
          state_d   = S_RESP;
          respcyc_d = 1'b1;
          resp_d    = rdata_c;
          resptag_d = tag_q;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      S_RESP: begin
        if (bus.respack) begin
          if (beat_q == 3'd7) begin
            respcyc_d = 1'b0;
            resp_d    = '0;
            state_d   = S_IDLE;
          end else begin
            rbeat_c = beat_q + 3'd1;
            beat_d  = rbeat_c;
            resp_d  = rdata_c;
          end
        end
      end

      S_WDATA: begin
        if (bus.reqcyc) begin
          we_c = 1'b1;
          if (beat_q == 3'd7) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      tag_q       <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      bus.reqack  <= 1'b0;
      bus.respcyc <= 1'b0;
      bus.resp    <= '0;
      bus.resptag <= '0;
      busy        <= 1'b0;
      bad_type    <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      tag_q       <= tag_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      bus.reqack  <= reqack_d;
      bus.respcyc <= respcyc_d;
      bus.resp    <= resp_d;
      bus.resptag <= resptag_d;
      busy        <= busy_d;
      bad_type    <= bad_type_d;
    end
  end

  // Line storage; reset does not clear contents
  always_ff @(posedge clk) begin
    if (we_c && !reset) begin
      mem[ADDR_W'({line_q, beat_q})] <= bus.req;
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: directed reads/writes with stalls, wrap, bad type and reset.
module tb_sysbus_mem_responder;

  localparam int unsigned MEM_LINES  = 1024;
  localparam int unsigned RD_LATENCY = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy, bad_type;
  logic ack_en;

  always #5 clk = ~clk;

  sysbus_if bus ();
  assign bus.respack = bus.respcyc & ack_en;

  sysbus_mem_responder #(
    .MEM_LINES (MEM_LINES),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .bad_type(bad_type)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   req_cyc = 0;
  int   first_cyc = 0;
  bit   first_arm = 1'b0;
  int   pops = 0;
  exp_t expq[$];
  logic [63:0] model [MEM_LINES][8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented beat with the head of the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.respcyc) begin
      if (first_arm) begin
        first_cyc = cyc;
        first_arm = 1'b0;
      end
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat actual resp=%h tag=%h required no beat", bus.resp, bus.resptag);
      end else begin
        e = expq[0];
        if (bus.resp !== e.data || bus.resptag !== e.tag) begin
          bad++;
          $display("FAIL beat actual resp=%h tag=%h required resp=%h tag=%h",
                   bus.resp, bus.resptag, e.data, e.tag);
        end
        if (bus.respack) begin
          e = expq.pop_front();
          pops++;
        end
      end
    end
  end

  task automatic request(input logic [63:0] addr, input logic [12:0] tag);
    @(posedge clk); #1;
    bus.reqcyc = 1'b1;
    bus.req    = addr;
    bus.reqtag = tag;
    req_cyc    = cyc;
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
    bus.req    = '0;
    check("reqack_pulse", 64'(bus.reqack), 64'd1);
    check("busy_in_ack", 64'(busy), 64'd1);
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [63:0] base, input int nbeats,
                            input int stall_after, input bit do_reset);
    int line;
    line = int'(addr[15:6]);
    request(addr, 13'h0100);
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      if (i == stall_after) begin
        bus.reqcyc = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
      bus.reqcyc = 1'b1;
      bus.req    = base + 64'(i);
      model[line][i] = base + 64'(i);
    end
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
    bus.req    = '0;
    if (do_reset) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
    check("busy_after_write", 64'(busy), 64'd0);
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [7:0] priv, input int stall_beat,
                           input int reset_beat, input bit check_lat);
    int          line;
    logic [12:0] tag;
    int          n;
    bit          done;
    bit          stalled;
    line    = int'(addr[15:6]);
    tag     = {1'b1, 4'b0001, priv};
    n       = 0;
    done    = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 8; i++) expq.push_back('{data: model[line][i], tag: tag});
    pops      = 0;
    first_arm = 1'b1;
    ack_en    = 1'b1;
    request(addr, tag);
    @(posedge clk); #1;
    check("reqack_single", 64'(bus.reqack), 64'd0);
    while (!done && n < 100) begin
      if (expq.size() == 0) begin
        done = 1'b1;
      end else if (stall_beat >= 0 && !stalled && bus.respcyc && pops == stall_beat) begin
        ack_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ack_en  = 1'b1;
        stalled = 1'b1;
      end else if (reset_beat >= 0 && bus.respcyc && pops == reset_beat) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_reqack", 64'(bus.reqack), 64'd0);
        check("rst_respcyc", 64'(bus.respcyc), 64'd0);
        check("rst_resp", bus.resp, 64'd0);
        check("rst_resptag", 64'(bus.resptag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bad_type", 64'(bad_type), 64'd0);
        expq.delete();
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL read_timeout actual beats_left=%0d required 0", expq.size());
      expq.delete();
    end
    if (check_lat) check("first_beat_cycle", 64'(first_cyc), 64'(req_cyc + int'(RD_LATENCY) + 1));
    check("respcyc_after_read", 64'(bus.respcyc), 64'd0);
    check("busy_after_read", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int l = 0; l < int'(MEM_LINES); l++)
      for (int w = 0; w < 8; w++) model[l][w] = '0;
    bus.reqcyc = 1'b0;
    bus.req    = '0;
    bus.reqtag = '0;
    ack_en     = 1'b1;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_reqack", 64'(bus.reqack), 64'd0);
    check("reset_respcyc", 64'(bus.respcyc), 64'd0);
    check("reset_resp", bus.resp, 64'd0);
    check("reset_resptag", 64'(bus.resptag), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_bad_type", 64'(bad_type), 64'd0);
    reset = 1'b0;

    // Line 3 = 0x1000..0x1007, read back with latency check
    write_line(64'hC0, 64'h1000, 8, -1, 1'b0);
    read_line(64'hC0, 8'h02, -1, -1, 1'b1);

    // Line 5 with a 2-cycle write gap between beats 4 and 5, then a 3-cycle stall on beat 2
    write_line(64'h140, 64'hA0, 8, 5, 1'b0);
    read_line(64'h140, 8'h07, 2, -1, 1'b0);

    // High address bits discarded: 0x10040 lands in line 1
    write_line(64'h10040, 64'h5500, 8, -1, 1'b0);
    read_line(64'h40, 8'h11, -1, -1, 1'b0);

    // Non-MEMORY type: ack only, sticky error, no data phase
    request(64'h0, {1'b1, 4'b0010, 8'h00});
    @(posedge clk); #1;
    check("bad_type_set", 64'(bad_type), 64'd1);
    check("bad_type_busy", 64'(busy), 64'd0);
    check("bad_type_reqack_low", 64'(bus.reqack), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_type_sticky", 64'(bad_type), 64'd1);

    // Reset during read beat 3 of line 3
    read_line(64'hC0, 8'h02, -1, 3, 1'b0);

    // Partial write aborted by reset keeps words 0..3 new and 4..7 old
    write_line(64'h200, 64'h7700, 8, -1, 1'b0);
    write_line(64'h200, 64'h8800, 4, -1, 1'b1);
    check("partial_model_w3", model[8][3], 64'h8803);
    check("partial_model_w4", model[8][4], 64'h7704);
    read_line(64'h200, 8'h33, -1, -1, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
